// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_unit_pkg;

    localparam int MD_XLEN   = 64;
    localparam int MD_WLEN   = 32;
    localparam int MD_ITER_D = 64;
    localparam int MD_ITER_W = 32;

    // Operation select driven by the execute stage.
    typedef enum logic [1:0] {
        MD_MUL = 2'd0,
        MD_DIV = 2'd1,
        MD_REM = 2'd2
    } md_func_t;

    // Controller states. The literals carry an MDS_ prefix so they do not
    // collide with the md_func_t literals in this package.
    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_MUL  = 2'd1,
        MDS_DIV  = 2'd2,
        MDS_DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/muldiv_unit_prep.sv
// Combinational operand preparation: word extension, divide magnitudes and
// result signs, plus detection of divide-by-zero and signed overflow.
module muldiv_prep
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = MD_XLEN,
    parameter int WLEN = MD_WLEN
) (
    input  logic [1:0]      func,
    input  logic            unsign,
    input  logic            word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] dvd_mag,
    output logic [XLEN-1:0] dvs_mag,
    output logic            neg_q,
    output logic            neg_r,
    output logic            special,
    output logic [XLEN-1:0] special_res
);

    logic [XLEN-1:0] ext_a;
    logic [XLEN-1:0] ext_b;
    logic [XLEN-1:0] a_sx;
    logic [XLEN-1:0] min_neg;
    logic            sign_a;
    logic            sign_b;
    logic            div_zero;
    logic            ovf;
    logic            is_div;
    logic            is_rem;

    // Extend operands to the operating width, derive magnitudes and special results.
    always_comb begin
        ext_a = a;
        ext_b = b;
        if (word) begin
            ext_a = unsign ? {{(XLEN-WLEN){1'b0}}, a[WLEN-1:0]}
                           : {{(XLEN-WLEN){a[WLEN-1]}}, a[WLEN-1:0]};
            ext_b = unsign ? {{(XLEN-WLEN){1'b0}}, b[WLEN-1:0]}
                           : {{(XLEN-WLEN){b[WLEN-1]}}, b[WLEN-1:0]};
        end
        sign_a  = !unsign && ext_a[XLEN-1];
        sign_b  = !unsign && ext_b[XLEN-1];
        dvd_mag = sign_a ? -ext_a : ext_a;
        dvs_mag = sign_b ? -ext_b : ext_b;
        neg_q   = sign_a ^ sign_b;
        neg_r   = sign_a;

        // Most-negative value at the operating width, as seen after extension.
        min_neg  = word ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}}
                        : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = word ? (b[WLEN-1:0] == '0) : (b == '0);
        ovf      = !unsign && (ext_a == min_neg) && (ext_b == '1);
        is_div   = (func != MD_MUL);
        is_rem   = (func == MD_REM);
        special  = is_div && (div_zero || ovf);

        // The remainder of a divide-by-zero is the dividend, always sign-extended for word forms.
        a_sx = word ? {{(XLEN-WLEN){a[WLEN-1]}}, a[WLEN-1:0]} : a;
        special_res = '0;
        if (div_zero) begin
            special_res = is_rem ? a_sx : '1;
        end else if (ovf) begin
            special_res = is_rem ? '0 : ext_a;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a one-cycle done pulse and a held result.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = MD_XLEN,
    parameter int WLEN = MD_WLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      func,
    input  logic            unsign,
    input  logic            word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] result
);

    md_state_t       state_reg, state_next;
    logic [6:0]      cnt_reg, cnt_next;
    logic [XLEN-1:0] acc_reg, acc_next;     // product accumulator / partial remainder
    logic [XLEN-1:0] opa_reg, opa_next;     // multiplicand / dividend shifting into quotient
    logic [XLEN-1:0] opb_reg, opb_next;     // multiplier / divisor
    logic            neg_q_reg, neg_q_next;
    logic            neg_r_reg, neg_r_next;
    logic            word_reg, word_next;
    logic            rem_reg, rem_next;
    logic [XLEN-1:0] result_reg, result_next;

    logic [XLEN-1:0] dvd_mag, dvs_mag, special_res;
    logic            neg_q, neg_r, special;

    logic [XLEN-1:0] mul_acc;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] div_acc, div_opa, q_fix, r_fix, div_raw;

    muldiv_prep #(.XLEN(XLEN), .WLEN(WLEN)) u_prep (
        .func        (func),
        .unsign      (unsign),
        .word        (word),
        .a           (a),
        .b           (b),
        .dvd_mag     (dvd_mag),
        .dvs_mag     (dvs_mag),
        .neg_q       (neg_q),
        .neg_r       (neg_r),
        .special     (special),
        .special_res (special_res)
    );

    assign ready  = (state_reg == MDS_IDLE);
    assign done   = (state_reg == MDS_DONE);
    assign result = result_reg;

    // Next-state, iteration datapath and result formatting.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        opa_next    = opa_reg;
        opb_next    = opb_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        word_next   = word_reg;
        rem_next    = rem_reg;
        result_next = result_reg;

        mul_acc = acc_reg + (opb_reg[0] ? opa_reg : '0);
        rem_sh  = {acc_reg, opa_reg[XLEN-1]};
        diff    = rem_sh - {1'b0, opb_reg};
        div_acc = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
        div_opa = {opa_reg[XLEN-2:0], ~diff[XLEN]};
        q_fix   = neg_q_reg ? -div_opa : div_opa;
        r_fix   = neg_r_reg ? -div_acc : div_acc;
        div_raw = rem_reg ? r_fix : q_fix;

        case (state_reg)
            MDS_IDLE: begin
                if (start) begin
                    cnt_next   = word ? 7'(MD_ITER_W - 1) : 7'(MD_ITER_D - 1);
                    neg_q_next = neg_q;
                    neg_r_next = neg_r;
                    word_next  = word;
                    rem_next   = (func == MD_REM);
                    acc_next   = '0;
                    if (func == MD_MUL) begin
                        opa_next   = a;
                        opb_next   = b;
                        state_next = MDS_MUL;
                    end else if (special) begin
                        result_next = special_res;
                        state_next  = MDS_DONE;
                    end else begin
                        // Word dividends start at the top so the same 64-bit shift path applies.
                        opa_next   = word ? (dvd_mag << WLEN) : dvd_mag;
                        opb_next   = dvs_mag;
                        state_next = MDS_DIV;
                    end
                end
            end
            MDS_MUL: begin
                acc_next = mul_acc;
                opa_next = opa_reg << 1;
                opb_next = opb_reg >> 1;
                cnt_next = cnt_reg - 7'd1;
                if (cnt_reg == 7'd0) begin
                    result_next = word_reg ? {{(XLEN-WLEN){mul_acc[WLEN-1]}}, mul_acc[WLEN-1:0]}
                                           : mul_acc;
                    state_next  = MDS_DONE;
                end
            end
            MDS_DIV: begin
                acc_next = div_acc;
                opa_next = div_opa;
                cnt_next = cnt_reg - 7'd1;
                if (cnt_reg == 7'd0) begin
                    result_next = word_reg ? {{(XLEN-WLEN){div_raw[WLEN-1]}}, div_raw[WLEN-1:0]}
                                           : div_raw;
                    state_next  = MDS_DONE;
                end
            end
            default: begin
                state_next = MDS_IDLE;
            end
        endcase

        // Abort wins over everything, including a start or a completing iteration.
        if (flush) begin
            state_next  = MDS_IDLE;
            result_next = result_reg;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= MDS_IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            opa_reg    <= '0;
            opb_reg    <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            word_reg   <= 1'b0;
            rem_reg    <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            opa_reg    <= opa_next;
            opb_reg    <= opb_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            word_reg   <= word_next;
            rem_reg    <= rem_next;
            result_reg <= result_next;
        end
    end

endmodule
